regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with an integrated writeback scoreboard, for the pipelined and multi-cycle CPU datapaths.
- Two asynchronous read ports, one synchronous write port.
- Per-register busy bits: set when an instruction claiming a destination issues, cleared when that destination is written back.
- Hazard logic reads `rsN_busy` and `issue_ready` directly; no separate scoreboard module is needed.
- Optional same-cycle write-to-read bypass.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NREGS`, 32: register count, power of two, ≥ 4; `AW` = log2(`NREGS`).
- `SP_IDX`, 2: index of the stack-pointer register.
- `SP_INIT`, 32'h2ffc: stack-pointer reset value, `XLEN` bits.

Ports:
- One clock; reset is synchronous and active-high (ports `clk`, `reset`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `rs1`, `rs2`  in  `AW`  read addresses.
- `rs1_dout`, `rs2_dout`  out  `XLEN`  read data.
- `rs1_busy`, `rs2_busy`  out  1  source register has a pending write.
- `rd`  in  `AW`  writeback address.
- `rd_din`  in  `XLEN`  writeback data.
- `write_enable`  in  1  writeback strobe.
- `issue_valid`  in  1  an instruction with destination `issue_rd` requests issue.
- `issue_rd`  in  `AW`  destination being claimed.
- `issue_ready`  out  1  the issue is accepted this cycle.
- `busy_count`  out  `AW+1`  number of busy registers.
- `dbg_addr`  in  `AW`  debug read address.
- `dbg_dout`  out  `XLEN`  debug read data, always un-bypassed stored value.

## Operation
- State: `rf[0..NREGS-1]` (`XLEN` each), `busy[0..NREGS-1]`, `busy_count`.
- Reset, which has priority over all other activity:
  - all `rf` = 0 except `rf[SP_IDX]` = `SP_INIT`;
  - all `busy` = 0 and `busy_count` = 0.
- Register 0:
  - always reads 0 and is never busy;
  - writes and issues to it are ignored;
  - an issue to r0 is accepted with `issue_ready` = 1 and has no effect.
- Read, combinational: `rsN_dout` = `rf[rsN]`; `rsN_busy` = `busy[rsN]`.
- Write:
  - `write_enable` && `rd`≠0 → `rf[rd]` ← `rd_din` at the edge;
  - same edge clears `busy[rd]`;
  - a write to a non-busy register is legal: data updates, busy stays 0.
- Issue:
  - `issue_ready` = !`busy[issue_rd]` || (`write_enable` && `rd`==`issue_rd`);
  - the block refuses WAW hazards: a busy destination is accepted only if it is being written back this same cycle;
  - accepted issue (`issue_valid` && `issue_ready` && `issue_rd`≠0) sets `busy[issue_rd]` at the edge.
- Simultaneous write-clear and issue-set on the same register → set wins; busy stays 1, and the data written that cycle is stored.
- `busy_count` tracks busy bits: +1 on set, −1 on clear, unchanged when both occur on the same register.
  - Range 0..`NREGS-1` (r0 is never busy).
  - Must equal popcount(`busy`) at all times.

## Timing
- Read latency 0 cycles; combinational from address to data.
- Write visible on read ports the cycle after `write_enable`, or the same cycle with bypass.
- Busy set visible the cycle after the accepted issue.
- Busy clear visible the cycle after the write, or the same cycle with bypass.
- `issue_ready` is combinational from `issue_rd`, `rd`, `write_enable`, `busy`.
- Reset asserted mid-operation discards all pending busy state at that edge; any write in that cycle is dropped.
- All outputs after reset: `rsN_dout` = 0, or `SP_INIT` when addressing `SP_IDX`; `rsN_busy` = 0; `issue_ready` = 1; `busy_count` = 0.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - when `write_enable` && `rd`≠0 && `rsN`==`rd`, `rsN_dout` = `rd_din` and `rsN_busy` = 0 in that same cycle;
  - `dbg_dout` is unaffected.
- `REGFILE_BYPASS_EN` undefined:
  - reads return the stored `rf` value and the pre-edge busy bit;
  - the write is observed one cycle later.

## Test plan
- Reset, then read all registers → every `dout` 0 except `SP_IDX` = 32'h2ffc; `busy_count` 0; `issue_ready` 1.
- Issue `issue_rd`=5 → next cycle `rs1_busy`=1 for `rs1`=5, `busy_count`=1. Issue 5 again → `issue_ready`=0. Write `rd`=5, `rd_din`=32'hdeadbeef → next cycle busy 0, `dout` = 32'hdeadbeef, `busy_count` 0.
- Same cycle: write `rd`=7 (busy) and issue `issue_rd`=7 → `issue_ready`=1; next cycle `busy[7]`=1, `rf[7]` updated, `busy_count` unchanged.
- Write `rd`=0 with 32'h1234 and issue `issue_rd`=0 → r0 reads 0, never busy, `busy_count` 0.
- Write `rd`=3 with 32'h55 while `rs2`=3:
  - with `REGFILE_BYPASS_EN`, `rs2_dout`=32'h55 that cycle;
  - without it, the old value that cycle and 32'h55 the next;
  - `dbg_dout` shows the old value that cycle in both builds.
- Issue registers 1..4, assert reset mid-sequence with a concurrent write → all busy 0, `busy_count` 0, register file at reset values.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with an integrated writeback scoreboard.
//
// Holds NREGS registers of XLEN bits plus one busy bit per register. An
// issuing instruction claims its destination, which sets the busy bit. The
// writeback to that destination clears it. Hazard logic uses rsN_busy and
// issue_ready directly.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   rs1, rs2                combinational read addresses
//   rs1_dout, rs2_dout      read data
//   rs1_busy, rs2_busy      source register has a pending write
//   rd, rd_din, write_enable  synchronous writeback port (also clears busy)
//   issue_valid, issue_rd   destination claim request
//   issue_ready             claim accepted this cycle
//   busy_count              number of busy registers (popcount of busy)
//   dbg_addr, dbg_dout      debug read of the stored (never bypassed) value
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback data
// and busy-clear to the read ports. dbg_dout is never bypassed.
//
// Issue handshake: a claim happens on a rising edge where issue_valid and
// issue_ready are both 1. issue_ready does not depend on issue_valid, so
// hazard logic may sample it before it raises issue_valid. A claim on r0 is
// accepted but has no effect.

module regfile_sb #(
  parameter int              XLEN    = 32,
  parameter int              NREGS   = 32,
  parameter int              SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = 32'h2ffc,
  localparam int             AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_dout,
  output logic [XLEN-1:0] rs2_dout,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_din,
  input  logic            write_enable,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  output logic [AW:0]     busy_count,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_dout
);

  logic [XLEN-1:0] rf [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      count_q;

  logic wr_hit;
  logic issue_set;
  logic count_inc;
  logic count_dec;

  // Writes to r0 are dropped, so r0 stays zero and is never busy.
  assign wr_hit = write_enable && (rd != '0);

  // A busy destination is accepted only when it is being written back in this
  // cycle. Otherwise the claim would be a WAW hazard.
  assign issue_ready = !busy_q[issue_rd] || (write_enable && (rd == issue_rd));
  assign issue_set   = issue_valid && issue_ready && (issue_rd != '0);

  // Apply the clear first and the set second, so the set wins on the same
  // register.
  always_comb begin
    busy_d = busy_q;
    if (wr_hit)
      busy_d[rd] = 1'b0;
    if (issue_set)
      busy_d[issue_rd] = 1'b1;
  end

  // The count changes only when a bit actually flips. A set on a register
  // that is already busy can happen only together with a clear on the same
  // register, so the count stays the same in that case.
  assign count_inc = issue_set && !busy_q[issue_rd];
  assign count_dec = wr_hit && busy_q[rd] && !(issue_set && (issue_rd == rd));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= (i == SP_IDX) ? SP_INIT : '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_hit)
        rf[rd] <= rd_din;
      busy_q  <= busy_d;
      count_q <= count_q + {{AW{1'b0}}, count_inc} - {{AW{1'b0}}, count_dec};
    end
  end

  assign busy_count = count_q;

  always_comb begin
    rs1_dout = (rs1 == '0) ? '0 : rf[rs1];
    rs2_dout = (rs2 == '0) ? '0 : rf[rs2];
    rs1_busy = busy_q[rs1];
    rs2_busy = busy_q[rs2];
`ifdef REGFILE_BYPASS_EN
    if (wr_hit && (rs1 == rd)) begin
      rs1_dout = rd_din;
      rs1_busy = 1'b0;
    end
    if (wr_hit && (rs2 == rd)) begin
      rs2_dout = rd_din;
      rs2_busy = 1'b0;
    end
`endif
  end

  assign dbg_dout = (dbg_addr == '0) ? '0 : rf[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int SP_IDX = 2;
  localparam logic [XLEN-1:0] SP_INIT = 32'h2ffc;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   rs1 = '0, rs2 = '0, rd = '0, issue_rd = '0, dbg_addr = '0;
  logic [XLEN-1:0] rd_din = '0;
  logic            write_enable = 1'b0, issue_valid = 1'b0;
  logic [XLEN-1:0] rs1_dout, rs2_dout, dbg_dout;
  logic            rs1_busy, rs2_busy, issue_ready;
  logic [AW:0]     busy_count;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .SP_IDX(SP_IDX), .SP_INIT(SP_INIT)) dut (
    .clk(clk), .reset(reset),
    .rs1(rs1), .rs2(rs2), .rs1_dout(rs1_dout), .rs2_dout(rs2_dout),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd(rd), .rd_din(rd_din), .write_enable(write_enable),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .busy_count(busy_count), .dbg_addr(dbg_addr), .dbg_dout(dbg_dout)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard
  logic [XLEN-1:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;

  task automatic expect_val(input logic [XLEN-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic compare(input string name, input logic [XLEN-1:0] act);
    logic [XLEN-1:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s: got %h but no expected value queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_miss++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    expect_val(exp);
    compare(name, act);
  endtask

  // driver
  task automatic idle_inputs();
    write_enable = 1'b0;
    issue_valid  = 1'b0;
    issue_rd     = '0;
    rd           = '0;
    rd_din       = '0;
  endtask

  typedef struct {
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] din;
    logic            iv;
    logic [AW-1:0]   ird;
    logic [AW-1:0]   rs;
    logic            exp_ready;
    logic [XLEN-1:0] exp_dout;
    logic            exp_busy;
    logic [AW:0]     exp_count;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [AW-1:0] r, input logic [XLEN-1:0] d,
                              input logic iv, input logic [AW-1:0] ir, input logic [AW-1:0] rs,
                              input logic er, input logic [XLEN-1:0] ed, input logic eb,
                              input logic [AW:0] ec);
    vec_t v;
    v.we = we; v.rd = r; v.din = d; v.iv = iv; v.ird = ir; v.rs = rs;
    v.exp_ready = er; v.exp_dout = ed; v.exp_busy = eb; v.exp_count = ec;
    return v;
  endfunction

  // One cycle of write/issue, then a read-back after the edge with the
  // write/issue inputs released.
  task automatic apply(input vec_t v, input int idx);
    write_enable = v.we; rd = v.rd; rd_din = v.din;
    issue_valid = v.iv; issue_rd = v.ird;
    #1;
    chk($sformatf("v%0d issue_ready", idx), {31'b0, issue_ready}, {31'b0, v.exp_ready});
    @(posedge clk); #1;
    idle_inputs();
    rs1 = v.rs;
    #1;
    chk($sformatf("v%0d rs1_dout", idx), rs1_dout, v.exp_dout);
    chk($sformatf("v%0d rs1_busy", idx), {31'b0, rs1_busy}, {31'b0, v.exp_busy});
    chk($sformatf("v%0d busy_count", idx), {26'b0, busy_count}, {26'b0, v.exp_count});
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      logic [XLEN-1:0] e;
      e = (i == SP_IDX) ? SP_INIT : '0;
      rs1 = i[AW-1:0]; rs2 = i[AW-1:0]; dbg_addr = i[AW-1:0];
      #1;
      chk($sformatf("%s rs1_dout[%0d]", tag, i), rs1_dout, e);
      chk($sformatf("%s rs2_dout[%0d]", tag, i), rs2_dout, e);
      chk($sformatf("%s dbg_dout[%0d]", tag, i), dbg_dout, e);
      chk($sformatf("%s rs1_busy[%0d]", tag, i), {31'b0, rs1_busy}, 32'd0);
    end
    chk({tag, " busy_count"}, {26'b0, busy_count}, 32'd0);
    chk({tag, " issue_ready"}, {31'b0, issue_ready}, 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    //          we  rd     din            iv  ird    rs     rdy  dout           busy cnt
    vecs[0] = mk(0, 5'd0, 32'h0,        1, 5'd5, 5'd5, 1, 32'h0,        1, 6'd1);
    vecs[1] = mk(0, 5'd0, 32'h0,        1, 5'd5, 5'd5, 0, 32'h0,        1, 6'd1);
    vecs[2] = mk(1, 5'd5, 32'hdeadbeef, 0, 5'd0, 5'd5, 1, 32'hdeadbeef, 0, 6'd0);
    vecs[3] = mk(0, 5'd0, 32'h0,        1, 5'd7, 5'd7, 1, 32'h0,        1, 6'd1);
    vecs[4] = mk(1, 5'd7, 32'h777,      1, 5'd7, 5'd7, 1, 32'h777,      1, 6'd1);
    vecs[5] = mk(1, 5'd0, 32'h1234,     1, 5'd0, 5'd0, 1, 32'h0,        0, 6'd1);
    vecs[6] = mk(1, 5'd7, 32'ha5,       0, 5'd0, 5'd7, 1, 32'ha5,       0, 6'd0);
    vecs[7] = mk(1, 5'd9, 32'h99,       0, 5'd0, 5'd9, 1, 32'h99,       0, 6'd0);
    vecs[8] = mk(0, 5'd0, 32'h0,        1, 5'd2, 5'd2, 1, SP_INIT,      1, 6'd1);
    vecs[9] = mk(1, 5'd2, 32'h22,       1, 5'd3, 5'd3, 1, 32'h0,        1, 6'd1);

    // reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset");

    // table vectors
    foreach (vecs[i]) apply(vecs[i], i);

    // writeback to busy r3 while rs2 and dbg look at r3
    rs2 = 5'd3; dbg_addr = 5'd3;
    write_enable = 1'b1; rd = 5'd3; rd_din = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass rs2_dout same cycle", rs2_dout, 32'h55);
    chk("bypass rs2_busy same cycle", {31'b0, rs2_busy}, 32'd0);
`else
    chk("nobypass rs2_dout same cycle", rs2_dout, 32'h0);
    chk("nobypass rs2_busy same cycle", {31'b0, rs2_busy}, 32'd1);
`endif
    chk("dbg_dout same cycle", dbg_dout, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("rs2_dout next cycle", rs2_dout, 32'h55);
    chk("rs2_busy next cycle", {31'b0, rs2_busy}, 32'd0);
    chk("dbg_dout next cycle", dbg_dout, 32'h55);
    chk("busy_count after r3 write", {26'b0, busy_count}, 32'd0);

    // issue r1..r3, then reset arrives with a write and an issue in flight
    for (int i = 1; i <= 3; i++) begin
      issue_valid = 1'b1; issue_rd = i[AW-1:0];
      @(posedge clk); #1;
    end
    idle_inputs();
    #1;
    chk("busy_count before reset", {26'b0, busy_count}, 32'd3);
    issue_valid = 1'b1; issue_rd = 5'd4;
    write_enable = 1'b1; rd = 5'd9; rd_din = 32'hbad;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    check_reset_state("midreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
